nor_chain_sequencer: RTL and testbench
======================================

// Module: nor_chain_sequencer
// PURPOSE
//   Time-multiplexed evaluator for an N-input cascaded NOR chain.
//   Stage k: stage[k] = ~(prev | in[k+1]); prev = in[0] for k=0, else stage[k-1].
//   One shared 2-input NOR is stepped across the chain, one stage per clock.
//   A start/busy/done handshake lets a test harness or top-level FSM fire
//   evaluations back to back and read every intermediate stage.
// PARAMETERS
//   N_INPUTS  4  chain inputs, >=2; produces N_INPUTS-1 stage outputs
//   CNT_W     8  width of completed-evaluation counter
// PORTS
//   clk        in   1           rising-edge clock, single clock domain
//   reset      in   1           asynchronous, active-high reset
//   start      in   1           request evaluation; sampled only in IDLE
//   in_vec     in   N_INPUTS    chain inputs; bit0=first input (a), bit1=b, ...
//   busy       out  1           high from accepted start through DONE cycle
//   done       out  1           one-cycle pulse: stage_out/result valid
//   stage_out  out  N_INPUTS-1  intermediate NOR outputs; bit0=e, bit1=f, ...
//   result     out  1           final stage = stage_out[N_INPUTS-2]
//   eval_count out  CNT_W       number of completed evaluations, wraps
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; busy=0, done=0, stage_out=0,
//     result=0, eval_count=0, internal in_reg=0, idx=0.
//   FSM: IDLE -> EVAL -> DONE -> IDLE. No other states; encode with 2 bits.
//   Unused encodings return to IDLE.
//   IDLE: busy=0. If start=1 at edge: in_reg<=in_vec, idx<=0, stage_out<=0,
//     go EVAL. If start=0, hold all outputs, including last result.
//   EVAL: busy=1. Each edge: stage_out[idx] <= ~(op_a | in_reg[idx+1]).
//     op_a = in_reg[0] when idx=0, else stage_out[idx-1].
//     If idx==N_INPUTS-2: go DONE. Else idx<=idx+1.
//   DONE: busy=1, done=1 for exactly one cycle. Next edge: go IDLE,
//     eval_count<=eval_count+1 with modulo 2^CNT_W wrap.
//   Latency: start edge T0 -> done high in cycle after edge T0+(N_INPUTS-1).
//     N=4: done visible 3 cycles after start edge. Throughput: one
//     evaluation per N_INPUTS+1 cycles.
//   in_vec is captured once at start. Changes during EVAL/DONE are ignored.
//   start while busy (EVAL or DONE) is ignored and not queued.
//   start held high continuously: a new evaluation begins on the first edge
//     in IDLE, i.e. back-to-back with one IDLE cycle between runs.
//   stage_out shows partial results during EVAL. It is valid only when done=1
//     and holds that value through IDLE until the next accepted start.
//   result is a combinational copy of stage_out[N_INPUTS-2].
//   Reset mid-EVAL: abort immediately. No done pulse, and eval_count is
//     not incremented.
// TESTING
//   N=4, in_vec=4'b0000, start pulse -> done on 3rd cycle,
//     stage_out=3'b101, result=1.
//   in_vec=4'b0001 (a=1) -> stage_out=3'b010, result=0.
//   in_vec=4'b1000 (d=1) -> stage_out=3'b001, result=0.
//   in_vec=4'b0100 (c=1) -> stage_out=3'b101, result=1.
//   in_vec changed to 4'b1111 and start re-pulsed during EVAL -> current
//     run finishes with original values, no second run, eval_count +1 only.
//   Start held high for 3 runs -> busy low exactly 1 cycle between runs,
//     eval_count=3.
//   Reset asserted mid-EVAL -> all outputs 0 asynchronously, no done,
//     eval_count=0.
//   CNT_W=2, 5 runs -> eval_count=1 after wrap.
//   Random sweep of all 16 in_vec values vs golden e,f,g model.

Source files
------------

// File: rtl/nor_chain_sequencer.sv
// rtl/nor_chain_sequencer.sv - time-multiplexed cascaded NOR chain evaluator with start/busy/done handshake
module nor_chain_sequencer #(
  parameter int N_INPUTS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_INPUTS-1:0]   in_vec,
  output logic                  busy,
  output logic                  done,
  output logic [N_INPUTS-2:0]   stage_out,
  output logic                  result,
  output logic [CNT_W-1:0]      eval_count
);

  // idx only ever reaches N_INPUTS-2; clog2(N_INPUTS) keeps it at least one bit wide
  localparam int IDX_W = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                state;
  logic [N_INPUTS-1:0]   in_reg;
  logic [IDX_W-1:0]      idx;
  logic                  op_a;
  logic                  op_b;
  logic                  nor_bit;
  logic [N_INPUTS-2:0]   stage_next;

  // Operand select for the shared NOR: first stage takes in_reg[0], later stages chain the previous stage
  always_comb begin
    op_a = in_reg[0];
    op_b = in_reg[1];
    for (int k = 1; k < N_INPUTS - 1; k++) begin
      if (idx == IDX_W'(k)) begin
        op_a = stage_out[k-1];
        op_b = in_reg[k+1];
      end
    end
    nor_bit = ~(op_a | op_b);
  end

  // Merge the freshly computed stage bit into the stage vector at position idx
  always_comb begin
    stage_next = stage_out;
    for (int k = 0; k < N_INPUTS - 1; k++) begin
      if (idx == IDX_W'(k)) begin
        stage_next[k] = nor_bit;
      end
    end
  end

  assign result = stage_out[N_INPUTS-2];

  // Sequencer FSM: IDLE -> EVAL (one stage per clock) -> DONE -> IDLE, all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      stage_out  <= '0;
      eval_count <= '0;
      in_reg     <= '0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            in_reg    <= in_vec;
            idx       <= '0;
            stage_out <= '0;
            busy      <= 1'b1;
            state     <= EVAL;
          end
        end
        EVAL: begin
          stage_out <= stage_next;
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          eval_count <= eval_count + 1'b1;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_chain_sequencer.sv
// tb/tb_nor_chain_sequencer.sv - directed table-driven bench for nor_chain_sequencer
module tb_nor_chain_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start2;
  logic [3:0] in_vec;
  logic       busy, done, result;
  logic [2:0] stage_out;
  logic [7:0] eval_count;
  logic       busy2, done2, result2;
  logic [2:0] stage_out2;
  logic [1:0] eval_count2;

  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] exp_cnt;

  typedef struct {
    logic [3:0] v;
    logic [2:0] es;
    logic       er;
  } vec_t;

  vec_t tbl[4];

  nor_chain_sequencer #(.N_INPUTS(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec),
    .busy(busy), .done(done), .stage_out(stage_out), .result(result),
    .eval_count(eval_count)
  );

  nor_chain_sequencer #(.N_INPUTS(4), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_vec(in_vec),
    .busy(busy2), .done(done2), .stage_out(stage_out2), .result(result2),
    .eval_count(eval_count2)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] golden(input logic [3:0] v);
    logic e, f, g;
    e = ~(v[0] | v[1]);
    f = ~(e | v[2]);
    g = ~(f | v[3]);
    return {g, f, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 8'd0;
  endtask

  task automatic run(input logic [3:0] v, input logic [2:0] es, input logic er);
    int lat;
    @(negedge clk);
    in_vec = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 3);
    check("stage_out", stage_out, es);
    check("result", result, er);
    check("busy_in_done", busy, 1'b1);
    exp_cnt = exp_cnt + 8'd1;
    @(posedge clk); #1;
    check("done_pulse_width", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("eval_count", eval_count, exp_cnt);
    check("stage_hold", stage_out, es);
  endtask

  initial begin
    int lat, runs, gap, cyc;
    logic seen;

    tbl[0] = '{v: 4'b0000, es: 3'b101, er: 1'b1};
    tbl[1] = '{v: 4'b0001, es: 3'b010, er: 1'b0};
    tbl[2] = '{v: 4'b1000, es: 3'b001, er: 1'b0};
    tbl[3] = '{v: 4'b0100, es: 3'b101, er: 1'b1};

    reset  = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    in_vec = 4'b0000;
    exp_cnt = 8'd0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stage", stage_out, 3'b000);
    check("rst_result", result, 1'b0);
    check("rst_count", eval_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run(tbl[i].v, tbl[i].es, tbl[i].er);
    end

    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      logic [2:0] g;
      v = 4'(i);
      g = golden(v);
      run(v, g, g[2]);
    end

    // in_vec change and start re-pulse during EVAL are ignored
    do_reset();
    @(negedge clk);
    in_vec = 4'b0001;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    in_vec = 4'b1111;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("repulse_done_seen", done, 1'b1);
    check("repulse_stage", stage_out, 3'b010);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) seen = 1'b1;
    end
    check("repulse_no_second_run", seen, 1'b0);
    check("repulse_count", eval_count, 8'd1);

    // start held high: back-to-back runs with one idle cycle between
    do_reset();
    @(negedge clk);
    in_vec = 4'b0000;
    start  = 1'b1;
    runs = 0;
    gap  = 0;
    cyc  = 0;
    seen = 1'b0;
    while (runs < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (busy === 1'b1) begin
        if (gap > 0) check("held_gap", gap, 1);
        gap  = 0;
        seen = 1'b1;
      end else if (seen) begin
        gap++;
      end
      if (done === 1'b1) begin
        runs++;
        if (runs == 3) start = 1'b0;
      end
    end
    check("held_runs", runs, 3);
    @(posedge clk); #1;
    check("held_count", eval_count, 8'd3);
    check("held_idle", busy, 1'b0);

    // reset mid-EVAL aborts asynchronously
    do_reset();
    run(4'b0000, 3'b101, 1'b1);
    @(negedge clk);
    in_vec = 4'b0001;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_stage", stage_out, 3'b000);
    check("abort_result", result, 1'b0);
    check("abort_count", eval_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    check("abort_count_after", eval_count, 8'd0);

    // narrow counter wraps: 5 runs with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      lat = 0;
      while (done2 !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("wrap_latency", lat, 3);
      @(posedge clk); #1;
      if (i == 3) check("wrap_count_4", eval_count2, 2'd0);
    end
    check("wrap_count_5", eval_count2, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
